div_seq_signed: RTL
===================

// Module: div_seq_signed
// PURPOSE
//   Iterative signed divider for the multdiv unit. Converts operands to magnitude
//   (bitwise invert + 1, the negation path used across multdiv), runs one restoring
//   shift/subtract step per clock, then re-applies the sign to the quotient.
//   Sits beside the multiplier and is muxed onto the shared multdiv result/ready outputs.
// PARAMETERS
//   WIDTH  32  operand/quotient width in bits; iteration count = WIDTH
// PORTS
//   clock            in   1      system clock, rising edge
//   reset            in   1      synchronous, active-high
//   ctrl_DIV         in   1      start pulse; operands sampled on same edge
//   data_operandA    in   WIDTH  dividend, two's complement
//   data_operandB    in   WIDTH  divisor, two's complement
//   data_result      out  WIDTH  quotient, registered, held until next start
//   data_exception   out  1      divide-by-zero or overflow, valid with ready
//   data_resultRDY   out  1      one-cycle pulse: result/exception valid
//   busy             out  1      high while computing
// BEHAVIOUR
//   Reset (edge with reset=1): state IDLE; data_result=0, data_exception=0,
//     data_resultRDY=0, busy=0. Reset wins over ctrl_DIV on the same edge.
//     Reset mid-operation aborts the operation; no ready pulse follows.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: on edge with ctrl_DIV=1, latch |A|, |B|, neg_q = A[W-1]^B[W-1];
//     clear remainder and count; go to RUN (busy=1 from next cycle).
//     If B==0: skip RUN, go to DONE with result 0, exception 1.
//     If A==0x8000_0000 and B==all-ones: skip RUN, go to DONE with
//     result 0x8000_0000, exception 1.
//   RUN: per edge, shift {rem,dvd} left 1; if rem >= |B| then rem -= |B|
//     and shift in quotient bit 1, else 0. Exactly WIDTH edges, then DONE.
//     Subtraction is (WIDTH+1) bits wide so |B|=2^(W-1) compares correctly.
//   DONE (one cycle): data_result = neg_q ? (~q + 1) : q; data_resultRDY=1;
//     busy=0; return to IDLE. Zero quotient is never negated (stays 0).
//   Latency: normal op -> data_resultRDY high in cycle WIDTH+1 after the ctrl_DIV
//     cycle (33 for WIDTH=32); exception cases -> cycle 1 after ctrl_DIV.
//   Rounding: truncation toward zero. Remainder is not output.
//   ctrl_DIV while busy: current op aborted, new operands latched, restart;
//     no ready pulse for the aborted op.
//   ctrl_DIV in DONE cycle: ready pulse for finished op still issues; new op
//     starts on that same edge.
//   data_result/data_exception change only on the DONE edge or reset.
//   data_resultRDY never high two consecutive cycles.
// TESTING
//   1 A=100, B=7, pulse ctrl_DIV -> RDY exactly 33 cycles later,
//     result=14, exc=0
//   2 A=-100 (0xFFFFFF9C), B=7 -> result 0xFFFFFFF2 (-14); A=-100, B=-7 -> 14;
//     A=3, B=-7 -> 0
//   3 A=5, B=0 -> RDY 1 cycle after start, result=0, exc=1;
//     A=0x80000000, B=-1 -> result 0x80000000, exc=1
//   4 A=0x80000000, B=0x80000000 -> result 1; A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF
//   5 start 100/7, re-pulse ctrl_DIV at cycle 10 with 81/9 -> single RDY
//     33 cycles after 2nd pulse, result=9
//   6 assert reset at cycle 20 of an op -> no RDY, all outputs 0 next cycle;
//     new op after release completes normally

Source files
------------

// File: rtl/div_seq_signed.sv
// Iterative signed restoring divider: magnitude conversion, one shift/subtract
// step per clock, sign re-applied to the quotient on completion.
module div_seq_signed #(
  parameter int WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ctrl_DIV,
  input  logic signed [WIDTH-1:0] data_operandA,
  input  logic signed [WIDTH-1:0] data_operandB,
  output logic signed [WIDTH-1:0] data_result,
  output logic                    data_exception,
  output logic                    data_resultRDY,
  output logic                    busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  rem_r, dvd_r, dsr_r, exc_val;
  logic [CW-1:0]     cnt;
  logic              neg_q, exc_pend;
  logic [WIDTH:0]    shifted, diff;
  logic              qbit, last;
  logic [WIDTH-1:0]  rem_n, dvd_n;
  logic              b_zero, ovf, start_exc;
  logic              load_exc_now, load_pend, load_q;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] u;
    u = x;
    return u[WIDTH-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic signed [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] q,
                                                         input logic neg);
    return (neg && (q != '0)) ? (~q + 1'b1) : q;
  endfunction

  assign b_zero    = (data_operandB == '0);
  assign ovf       = ($unsigned(data_operandA) == MIN_VAL) && ($unsigned(data_operandB) == '1);
  assign start_exc = b_zero || ovf;

  // One restoring step; the extra bit keeps |B| = 2^(W-1) comparable.
  always_comb begin
    shifted = {rem_r, dvd_r[WIDTH-1]};
    diff    = shifted - {1'b0, dsr_r};
    qbit    = ~diff[WIDTH];
    rem_n   = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_n   = {dvd_r[WIDTH-2:0], qbit};
  end

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // An exceptional start issued in the DONE cycle detours through RUN for one
  // cycle so two ready pulses can never be adjacent.
  always_comb begin
    state_n = state;
    if (ctrl_DIV) begin
      state_n = (start_exc && (state != DONE)) ? DONE : RUN;
    end else begin
      case (state)
        IDLE:    state_n = IDLE;
        RUN:     if (exc_pend || last) state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state == RUN);
    data_resultRDY = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (ctrl_DIV) begin
      rem_r    <= '0;
      dvd_r    <= mag(data_operandA);
      dsr_r    <= mag(data_operandB);
      neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      cnt      <= '0;
      exc_pend <= start_exc;
      exc_val  <= ovf ? MIN_VAL : '0;
    end else if (state == RUN) begin
      rem_r <= rem_n;
      dvd_r <= dvd_n;
      cnt   <= cnt + 1'b1;
    end
  end

  assign load_exc_now = ctrl_DIV && start_exc && (state != DONE);
  assign load_pend    = !ctrl_DIV && (state == RUN) && exc_pend;
  assign load_q       = !ctrl_DIV && (state == RUN) && !exc_pend && last;

  always_ff @(posedge clock) begin
    if (reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (load_exc_now) begin
      data_result    <= ovf ? MIN_VAL : '0;
      data_exception <= 1'b1;
    end else if (load_pend) begin
      data_result    <= exc_val;
      data_exception <= 1'b1;
    end else if (load_q) begin
      data_result    <= apply_sign(dvd_n, neg_q);
      data_exception <= 1'b0;
    end
  end

endmodule
